// File: rtl/rd_responder_pkg.sv
// Shared AXI read-side encodings and FSM states for rd_responder and rd_engine.
package rd_responder_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_SEND  = 2'b10
  } rd_state_e;

  // WRAP and reserved encodings step like INCR; only FIXED holds the address.
  function automatic logic burst_advances(input logic [1:0] burst);
    logic adv;
    case (burst)
      BURST_FIXED: adv = 1'b0;
      BURST_INCR:  adv = 1'b1;
      BURST_WRAP:  adv = 1'b1;
      default:     adv = 1'b1;
    endcase
    return adv;
  endfunction

endpackage

// File: rtl/rd_responder_if.sv
// AXI4 read address/data channel bundle between a read initiator and rd_responder.
interface rd_responder_if #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6,
  parameter int LEN_WIDTH  = 8
);
  logic                  arvalid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [ID_WIDTH-1:0]   arid;
  logic [LEN_WIDTH-1:0]  arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic [ID_WIDTH-1:0]   rid;
  logic [1:0]            rresp;
  logic                  rready;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rlast, rid, rresp
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rlast, rid, rresp
  );
endinterface

// File: rtl/rd_responder_mem.sv
// Word memory for rd_responder: one preload write port, one synchronous read port.
// The read register doubles as the R data output register and can be forced to zero.
module rd_responder_mem #(
  parameter int MEM_AW     = 10,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  we,
  input  logic [MEM_AW-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [MEM_AW-1:0]     raddr,
  input  logic                  rd_zero,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_r [2**MEM_AW];
  logic [DATA_WIDTH-1:0] q_r;

  // Preload write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register samples the array before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_r <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      q_r <= rd_zero ? {DATA_WIDTH{1'b0}} : mem_r[raddr];
    end
  end

  assign rdata = q_r;
endmodule

// File: rtl/rd_responder.sv
// AXI4 read responder answering single outstanding bursts from preloaded word memory.
// Optional error responses are enabled with the RD_RESP_ERR_EN macro.
module rd_responder
  import rd_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_AW     = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  rd_responder_if.slave         s_axi,
  input  logic                  mem_we,
  input  logic [MEM_AW-1:0]     mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int OFS = $clog2(BPB);

  rd_state_e             state_r, state_s;
  logic                  arready_r, arready_s;
  logic                  rvalid_r, rvalid_s;
  logic                  rlast_r, rlast_s;
  logic                  busy_r, busy_s;
  logic [ID_WIDTH-1:0]   rid_r, rid_s;
  logic [1:0]            rresp_r, rresp_s;
  logic [LEN_WIDTH-1:0]  len_r, len_s;
  logic [LEN_WIDTH-1:0]  beat_cnt_r, beat_cnt_s;
  logic [MEM_AW-1:0]     widx_r, widx_s;
  logic                  adv_r, adv_s;
  logic                  err_r, err_s;
  logic                  req_err_s;
  logic                  fetch_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  unused_s;

`ifdef RD_RESP_ERR_EN
  assign req_err_s = (s_axi.arsize != 3'(OFS)) || s_axi.arburst[1] ||
                     (|s_axi.araddr[ADDR_WIDTH-1:MEM_AW+OFS]);
  assign unused_s  = ^s_axi.araddr[OFS-1:0];
`else
  assign req_err_s = 1'b0;
  assign unused_s  = ^{s_axi.arsize, s_axi.araddr[ADDR_WIDTH-1:MEM_AW+OFS],
                       s_axi.araddr[OFS-1:0]};
`endif

  // Next-state and next-output logic for the IDLE/FETCH/SEND burst sequencer.
  always_comb begin
    state_s    = state_r;
    arready_s  = arready_r;
    rvalid_s   = rvalid_r;
    rlast_s    = rlast_r;
    busy_s     = busy_r;
    rid_s      = rid_r;
    rresp_s    = rresp_r;
    len_s      = len_r;
    beat_cnt_s = beat_cnt_r;
    widx_s     = widx_r;
    adv_s      = adv_r;
    err_s      = err_r;
    case (state_r)
      ST_IDLE: begin
        if (s_axi.arvalid && arready_r) begin
          state_s    = ST_FETCH;
          arready_s  = 1'b0;
          busy_s     = 1'b1;
          rid_s      = s_axi.arid;
          len_s      = s_axi.arlen;
          beat_cnt_s = {LEN_WIDTH{1'b0}};
          widx_s     = s_axi.araddr[MEM_AW+OFS-1:OFS];
          adv_s      = burst_advances(s_axi.arburst);
          err_s      = req_err_s;
          rresp_s    = req_err_s ? RESP_SLVERR : RESP_OKAY;
        end else begin
          arready_s = 1'b1;
        end
      end
      ST_FETCH: begin
        state_s  = ST_SEND;
        rvalid_s = 1'b1;
        rlast_s  = (beat_cnt_r == len_r);
      end
      ST_SEND: begin
        if (s_axi.rready) begin
          rvalid_s = 1'b0;
          rlast_s  = 1'b0;
          if (rlast_r) begin
            state_s   = ST_IDLE;
            busy_s    = 1'b0;
            arready_s = 1'b1;
          end else begin
            state_s    = ST_FETCH;
            beat_cnt_s = beat_cnt_r + LEN_WIDTH'(1'b1);
            widx_s     = adv_r ? widx_r + MEM_AW'(1'b1) : widx_r;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
        rlast_s   = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rlast_r    <= 1'b0;
      busy_r     <= 1'b0;
      rid_r      <= {ID_WIDTH{1'b0}};
      rresp_r    <= 2'b00;
      len_r      <= {LEN_WIDTH{1'b0}};
      beat_cnt_r <= {LEN_WIDTH{1'b0}};
      widx_r     <= {MEM_AW{1'b0}};
      adv_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      arready_r  <= arready_s;
      rvalid_r   <= rvalid_s;
      rlast_r    <= rlast_s;
      busy_r     <= busy_s;
      rid_r      <= rid_s;
      rresp_r    <= rresp_s;
      len_r      <= len_s;
      beat_cnt_r <= beat_cnt_s;
      widx_r     <= widx_s;
      adv_r      <= adv_s;
      err_r      <= err_s;
    end
  end

  assign fetch_s = (state_r == ST_FETCH);

  rd_responder_mem #(
    .MEM_AW     (MEM_AW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .resetn  (resetn),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .re      (fetch_s),
    .raddr   (widx_r),
    .rd_zero (err_r),
    .rdata   (rdata_s)
  );

  assign s_axi.arready = arready_r;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rdata   = rdata_s;
  assign s_axi.rlast   = rlast_r;
  assign s_axi.rid     = rid_r;
  assign s_axi.rresp   = rresp_r;
  assign busy          = busy_r;
endmodule

// File: tb/tb_rd_responder.sv
// Randomized bench for rd_responder against a burst-level reference model.
module tb_rd_responder;
  import rd_responder_pkg::*;

  localparam int AW   = 33;
  localparam int DW   = 256;
  localparam int IW   = 6;
  localparam int LW   = 8;
  localparam int MAW  = 10;
  localparam int OFS  = 5;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } beat_t;

  logic clk = 1'b0;
  logic resetn;
  logic mem_we;
  logic [MAW-1:0] mem_waddr;
  logic [DW-1:0]  mem_wdata;
  logic busy;

  always #5 clk = ~clk;

  rd_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) axi ();

  rd_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .MEM_AW(MAW)) dut (
    .clk(clk), .resetn(resetn), .s_axi(axi),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [DW-1:0] mm [DEPTH];
  beat_t exp_q[$];
  beat_t log_q[$];
  int    hs_q[$];
  bit    m_busy = 1'b0;
  bit    m_arready = 1'b0;
  bit    m_rst_prev = 1'b1;
  int    m_valid_at = 0;
  int    ar_cyc = 0;
  int    obs_lat = -1;
  bit    seen_first = 1'b0;

  int       rr_mode = 0;
  logic [3:0] pat = 4'b1001;
  int       pat_i = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expand one accepted request into its full list of expected beats.
  function automatic void build(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                                input logic [LW-1:0] len, input logic [2:0] size,
                                input logic [1:0] burst);
    logic [MAW-1:0] base;
    logic [MAW-1:0] idx;
    bit err;
    beat_t b;
    base = addr[MAW+OFS-1:OFS];
    err = 1'b0;
`ifdef RD_RESP_ERR_EN
    err = (size != 3'd5) || (burst >= 2'b10) || (addr[AW-1:MAW+OFS] != '0);
`else
    if (size == 3'd0) err = 1'b0;
`endif
    for (int i = 0; i <= int'(len); i++) begin
      idx    = (burst == 2'b00) ? base : base + MAW'(i);
      b.data = err ? '0 : mm[idx];
      b.last = (i == int'(len));
      b.id   = id;
      b.resp = err ? 2'b10 : 2'b00;
      exp_q.push_back(b);
    end
  endfunction

  // Per-cycle compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    bit exp_rv;
    beat_t ob;
    cyc++;
    exp_rv = m_busy && (cyc >= m_valid_at);
    if (m_rst_prev) begin
      chk("rst_arready", DW'(axi.arready), DW'(0));
      chk("rst_rvalid",  DW'(axi.rvalid),  DW'(0));
      chk("rst_rlast",   DW'(axi.rlast),   DW'(0));
      chk("rst_busy",    DW'(busy),        DW'(0));
      chk("rst_rdata",   axi.rdata,        DW'(0));
      chk("rst_rid",     DW'(axi.rid),     DW'(0));
      chk("rst_rresp",   DW'(axi.rresp),   DW'(0));
    end else begin
      chk("arready", DW'(axi.arready), DW'(m_arready));
      chk("busy",    DW'(busy),        DW'(m_busy));
      chk("rvalid",  DW'(axi.rvalid),  DW'(exp_rv));
      if (exp_rv && axi.rvalid && exp_q.size() > 0) begin
        chk("rdata", axi.rdata,        exp_q[0].data);
        chk("rlast", DW'(axi.rlast),   DW'(exp_q[0].last));
        chk("rid",   DW'(axi.rid),     DW'(exp_q[0].id));
        chk("rresp", DW'(axi.rresp),   DW'(exp_q[0].resp));
      end
      if (axi.rvalid && !seen_first) begin
        seen_first = 1'b1;
        obs_lat = cyc - ar_cyc;
      end
    end
    if (!resetn) begin
      m_busy = 1'b0;
      m_arready = 1'b0;
      exp_q.delete();
      m_rst_prev = 1'b1;
    end else begin
      m_rst_prev = 1'b0;
      if (!m_busy) begin
        if (m_arready && axi.arvalid) begin
          build(axi.araddr, axi.arid, axi.arlen, axi.arsize, axi.arburst);
          m_busy = 1'b1;
          m_arready = 1'b0;
          m_valid_at = cyc + 2;
          ar_cyc = cyc;
          seen_first = 1'b0;
        end else begin
          m_arready = 1'b1;
        end
      end else if (exp_rv && axi.rready) begin
        ob.data = axi.rdata; ob.last = axi.rlast; ob.id = axi.rid; ob.resp = axi.rresp;
        log_q.push_back(ob);
        hs_q.push_back(cyc);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          m_arready = 1'b1;
        end else begin
          m_valid_at = cyc + 2;
        end
      end
    end
  end

  // Initiator-side RREADY pattern generator.
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0: axi.rready = 1'b1;
      1: axi.rready = 1'($urandom_range(0, 1));
      2: begin axi.rready = pat[pat_i]; pat_i = (pat_i + 1) % 4; end
      default: axi.rready = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [DW-1:0] data);
    mem_we = 1'b1;
    mem_waddr = MAW'(idx);
    mem_wdata = data;
    mm[idx] = data;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic ar(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [LW-1:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    bit acc;
    acc = 1'b0;
    axi.arvalid = 1'b1; axi.araddr = addr; axi.arid = id;
    axi.arlen = len; axi.arsize = size; axi.arburst = burst;
    for (int i = 0; i < 2000; i++) begin
      acc = axi.arready;
      tick();
      if (acc) break;
    end
    axi.arvalid = 1'b0;
    if (!acc) chk("ar_timeout", DW'(0), DW'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", DW'(m_busy), DW'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [DW-1:0] w;
    resetn = 1'b0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    axi.arvalid = 1'b0; axi.araddr = '0; axi.arid = '0; axi.arlen = '0;
    axi.arsize = 3'd5; axi.arburst = BURST_INCR; axi.rready = 1'b1;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
      preload(i, w);
    end
    preload(5, {32{8'hA5}});
    for (int i = 0; i < 4; i++) preload(i, DW'(i + 1));

    // Single beat from word 5.
    log_q.delete();
    ar(33'h0A0, 6'h15, 8'd0, 3'd5, BURST_INCR);
    wait_idle();
    chk("t1_count", DW'(log_q.size()), DW'(1));
    chk("t1_data",  log_q[0].data, {32{8'hA5}});
    chk("t1_last",  DW'(log_q[0].last), DW'(1));
    chk("t1_resp",  DW'(log_q[0].resp), DW'(0));
    chk("t1_id",    DW'(log_q[0].id), DW'(6'h15));
    chk("t1_lat",   DW'(obs_lat), DW'(2));

    // INCR 4 beats, RREADY high: one beat per 2 cycles.
    log_q.delete(); hs_q.delete(); rr_mode = 0;
    ar(33'h0, 6'h03, 8'd3, 3'd5, BURST_INCR);
    wait_idle();
    chk("t2_count", DW'(log_q.size()), DW'(4));
    for (int i = 0; i < 4; i++) begin
      chk("t2_data", log_q[i].data, DW'(i + 1));
      chk("t2_last", DW'(log_q[i].last), DW'(i == 3));
    end
    chk("t2_spacing", DW'(hs_q[3] - hs_q[0]), DW'(6));

    // Same burst with RREADY stalls.
    log_q.delete(); rr_mode = 2; pat_i = 0;
    ar(33'h0, 6'h04, 8'd3, 3'd5, BURST_INCR);
    wait_idle();
    chk("t3_count", DW'(log_q.size()), DW'(4));
    for (int i = 0; i < 4; i++) chk("t3_data", log_q[i].data, DW'(i + 1));

    // FIXED burst of word 2 while a second request waits.
    log_q.delete(); rr_mode = 0;
    ar(33'h040, 6'h09, 8'd2, 3'd5, BURST_FIXED);
    ar(33'h020, 6'h01, 8'd0, 3'd5, BURST_INCR);
    wait_idle();
    chk("t4_count", DW'(log_q.size()), DW'(4));
    for (int i = 0; i < 3; i++) chk("t4_fixed", log_q[i].data, DW'(3));
    chk("t4_next", log_q[3].data, DW'(2));
    chk("t4_next_id", DW'(log_q[3].id), DW'(6'h01));

    // Reset while beat 2 of an 8-beat burst is presented.
    log_q.delete();
    axi.arvalid = 1'b0;
    ar(33'h0, 6'h02, 8'd7, 3'd5, BURST_INCR);
    for (int n = 0; n < 100 && log_q.size() < 1; n++) tick();
    for (int n = 0; n < 100 && !axi.rvalid; n++) tick();
    chk("t5_beats_before_rst", DW'(log_q.size()), DW'(1));
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    log_q.delete();
    ar(33'h0A0, 6'h11, 8'd0, 3'd5, BURST_INCR);
    wait_idle();
    chk("t5_after_data", log_q[0].data, {32{8'hA5}});

`ifdef RD_RESP_ERR_EN
    log_q.delete();
    ar(33'h0, 6'h07, 8'd1, 3'b100, BURST_INCR);
    wait_idle();
    chk("err_count", DW'(log_q.size()), DW'(2));
    chk("err_resp0", DW'(log_q[0].resp), DW'(2'b10));
    chk("err_resp1", DW'(log_q[1].resp), DW'(2'b10));
    chk("err_data0", log_q[0].data, DW'(0));
    chk("err_last0", DW'(log_q[0].last), DW'(0));
    chk("err_last1", DW'(log_q[1].last), DW'(1));
`endif

    // Longest burst, crossing the top of memory.
    log_q.delete();
    ar(33'(1000 * 32), 6'h3F, 8'd255, 3'd5, BURST_INCR);
    wait_idle();
    chk("t7_count", DW'(log_q.size()), DW'(256));
    chk("t7_wrap", log_q[24].data, mm[0]);

    // Randomized bursts with random back-pressure.
    rr_mode = 1;
    for (int r = 0; r < 25; r++) begin
      logic [AW-1:0] a;
      logic [2:0] sz;
      a = AW'($urandom_range(0, DEPTH - 1)) << OFS;
      a[OFS-1:0] = 5'($urandom);
      if ($urandom_range(0, 4) == 0) a[AW-1:MAW+OFS] = 18'($urandom);
      sz = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd5;
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
        preload($urandom_range(0, DEPTH - 1), w);
      end
      ar(a, 6'($urandom), 8'($urandom_range(0, 15)), sz, 2'($urandom));
      wait_idle();
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
